// File: rtl/sound_sequencer_pkg.sv
// Shared definitions for the game sound sequencer: sequence IDs, the
// controller state type and the fixed-priority event picker.
package sound_sequencer_pkg;

   // Sequence IDs as presented on seq_sel; they double as pending-bit indices.
   localparam logic [1:0] SEQ_START = 2'd0;
   localparam logic [1:0] SEQ_SCORE = 2'd1;
   localparam logic [1:0] SEQ_HIGH  = 2'd2;
   localparam logic [1:0] SEQ_END   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_GAP  = 2'd2
   } state_e;

   typedef struct packed {
      logic       valid;
      logic [1:0] id;
   } grant_t;

   // Highest-priority pending event: end > high score > start > score.
   function automatic grant_t prio_pick(input logic [3:0] pend);
      grant_t g;
      g.valid = 1'b1;
      if (pend[SEQ_END]) begin
         g.id = SEQ_END;
      end else if (pend[SEQ_HIGH]) begin
         g.id = SEQ_HIGH;
      end else if (pend[SEQ_START]) begin
         g.id = SEQ_START;
      end else if (pend[SEQ_SCORE]) begin
         g.id = SEQ_SCORE;
      end else begin
         g.valid = 1'b0;
         g.id    = SEQ_START;
      end
      return g;
   endfunction

   // One-hot pending-bit mask for a sequence ID.
   function automatic logic [3:0] seq_mask(input logic [1:0] id);
      return 4'(4'b0001 << id);
   endfunction

endpackage

// File: rtl/sound_sequencer_prio_enc.sv
// sound_prio_enc: combinational priority encoder over the pending event bits.
module sound_prio_enc
   import sound_sequencer_pkg::*;
(
   input  logic [3:0] pend_i,
   output logic [1:0] grant_id_o,
   output logic       grant_valid_o
);

   grant_t pick_s;

   // Resolve which pending event wins this cycle.
   always_comb begin
      pick_s = prio_pick(pend_i);
   end

   assign grant_id_o    = pick_s.id;
   assign grant_valid_o = pick_s.valid;

endmodule

// File: rtl/sound_sequencer.sv
// sound_sequencer: latches single-cycle sound event requests as sticky
// pending bits, grants them by priority and walks the tone generator through
// one note sequence per grant followed by a silent gap. An end request cuts
// short any other sequence that is playing or in its gap.
module sound_sequencer
   import sound_sequencer_pkg::*;
#(
   parameter int unsigned NOTE_TICKS = 32'd25_000_000,
   parameter int unsigned GAP_TICKS  = 32'd5_000_000,
   parameter int unsigned NUM_NOTES  = 32'd8
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic       flush,
   output logic [1:0] seq_sel,
   output logic [2:0] note_idx,
   output logic       tone_en,
   output logic       note_strobe,
   output logic       busy,
   output logic       done,
   output logic       preempted
);

   // Terminal counts; GAP_LAST is unused when there is no gap.
   localparam logic [31:0] NOTE_LAST = 32'(NOTE_TICKS - 32'd1);
   localparam logic [31:0] GAP_LAST  = (GAP_TICKS == 32'd0) ? 32'd0 : 32'(GAP_TICKS - 32'd1);
   localparam logic [2:0]  IDX_LAST  = 3'(NUM_NOTES - 32'd1);
   localparam logic        HAS_GAP   = (GAP_TICKS != 32'd0);

   state_e      state_q, state_d;
   logic [3:0]  pend_q, pend_d;
   logic [31:0] cnt_q, cnt_d;
   logic [1:0]  sel_q, sel_d;
   logic [2:0]  idx_q, idx_d;
   logic        tone_en_q, busy_q, strobe_q, done_q, pre_q;
   logic        strobe_d, pre_d, done_d;

   logic [3:0]  grant_mask_s;
   logic [1:0]  grant_id_s;
   logic        grant_valid_s;
   logic        preempt_s;

   sound_prio_enc u_prio (
      .pend_i        (pend_q),
      .grant_id_o    (grant_id_s),
      .grant_valid_o (grant_valid_s)
   );

   // An end request cuts into any running non-end sequence, gap included.
   assign preempt_s = (state_q != ST_IDLE) && pend_q[SEQ_END] && (sel_q != SEQ_END);

   // Next-state and next-output computation for the sequencing controller.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      sel_d        = sel_q;
      idx_d        = idx_q;
      strobe_d     = 1'b0;
      pre_d        = 1'b0;
      grant_mask_s = 4'b0000;
      if (flush) begin
         state_d = ST_IDLE;
         cnt_d   = 32'd0;
         sel_d   = SEQ_START;
         idx_d   = 3'd0;
      end else if (preempt_s) begin
         state_d      = ST_PLAY;
         sel_d        = SEQ_END;
         idx_d        = 3'd0;
         cnt_d        = 32'd0;
         strobe_d     = 1'b1;
         pre_d        = (state_q == ST_PLAY);
         grant_mask_s = seq_mask(SEQ_END);
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (grant_valid_s) begin
                  state_d      = ST_PLAY;
                  sel_d        = grant_id_s;
                  idx_d        = 3'd0;
                  cnt_d        = 32'd0;
                  strobe_d     = 1'b1;
                  grant_mask_s = seq_mask(grant_id_s);
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_PLAY: begin
               if (cnt_q == NOTE_LAST) begin
                  cnt_d = 32'd0;
                  if (idx_q == IDX_LAST) begin
                     state_d = HAS_GAP ? ST_GAP : ST_IDLE;
                  end else begin
                     idx_d    = idx_q + 3'd1;
                     strobe_d = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 32'd1;
               end
            end
            ST_GAP: begin
               if (cnt_q == GAP_LAST) begin
                  state_d = ST_IDLE;
                  cnt_d   = 32'd0;
               end else begin
                  cnt_d = cnt_q + 32'd1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = 32'd0;
            end
         endcase
      end
      // Requests merge into the sticky bits; the bit being granted drops.
      if (flush) begin
         pend_d = 4'b0000;
      end else begin
         pend_d = (pend_q | req) & ~grant_mask_s;
      end
      // done is registered, so it is raised for the cycle whose counter
      // will sit on the final terminal count of the last note.
      done_d = (state_d == ST_PLAY) && (idx_d == IDX_LAST) && (cnt_d == NOTE_LAST);
   end

   // Controller state and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         pend_q    <= 4'b0000;
         cnt_q     <= 32'd0;
         sel_q     <= SEQ_START;
         idx_q     <= 3'd0;
         tone_en_q <= 1'b0;
         busy_q    <= 1'b0;
         strobe_q  <= 1'b0;
         done_q    <= 1'b0;
         pre_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pend_q    <= pend_d;
         cnt_q     <= cnt_d;
         sel_q     <= sel_d;
         idx_q     <= idx_d;
         tone_en_q <= (state_d == ST_PLAY);
         busy_q    <= (state_d != ST_IDLE);
         strobe_q  <= strobe_d;
         done_q    <= done_d;
         pre_q     <= pre_d;
      end
   end

   assign seq_sel     = sel_q;
   assign note_idx    = idx_q;
   assign tone_en     = tone_en_q;
   assign busy        = busy_q;
   assign note_strobe = strobe_q;
   assign done        = done_q;
   assign preempted   = pre_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Self-checking bench for sound_sequencer: table-driven request patterns,
// directed corner sequences and random traffic against a cycle-level model
// that tracks elapsed play time rather than note/tick counters.
module tb_sound_sequencer;

   localparam int NT = 4;
   localparam int GT = 2;
   localparam int NN = 8;
   localparam int SEQ_CYC = NN * NT;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [3:0] req = 4'b0000;
   logic       flush = 1'b0;
   logic [1:0] seq_sel;
   logic [2:0] note_idx;
   logic       tone_en, note_strobe, busy, done, preempted;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   // Free-running cycle count for messages.
   always @(posedge clk) cyc <= cyc + 1;

   sound_sequencer #(.NOTE_TICKS(NT), .GAP_TICKS(GT), .NUM_NOTES(NN)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .flush       (flush),
      .seq_sel     (seq_sel),
      .note_idx    (note_idx),
      .tone_en     (tone_en),
      .note_strobe (note_strobe),
      .busy        (busy),
      .done        (done),
      .preempted   (preempted)
   );

   // ---------------- reference model ----------------
   // phase: 0 idle, 1 playing, 2 gap. el = cycles elapsed in current sequence.
   int         m_phase = 0;
   int         m_sel = 0;
   int         m_el = 0;
   int         m_gap = 0;
   logic [3:0] m_pend = 4'b0000;
   bit         m_pre = 1'b0;

   function automatic int pick(input logic [3:0] p);
      int order [4];
      order = '{3, 2, 0, 1};
      for (int i = 0; i < 4; i++) begin
         if (p[order[i]]) return order[i];
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_phase = 0; m_sel = 0; m_el = 0; m_gap = 0; m_pend = 4'b0000; m_pre = 1'b0;
   endtask

   task automatic model_step(input logic [3:0] r, input logic f);
      logic [3:0] mask;
      int id;
      mask = 4'b0000;
      if (f) begin
         m_pend = 4'b0000; m_phase = 0; m_pre = 1'b0;
         return;
      end
      m_pre = 1'b0;
      if (m_phase != 0 && m_pend[3] && m_sel != 3) begin
         m_pre = (m_phase == 1);
         m_phase = 1; m_sel = 3; m_el = 0; mask = 4'b1000;
      end else if (m_phase == 0) begin
         if (m_pend != 4'b0000) begin
            id = pick(m_pend);
            m_phase = 1; m_sel = id; m_el = 0;
            mask = 4'(4'b0001 << id);
         end
      end else if (m_phase == 1) begin
         if (m_el == SEQ_CYC - 1) begin
            if (GT > 0) begin m_phase = 2; m_gap = GT; end
            else m_phase = 0;
         end else begin
            m_el++;
         end
      end else begin
         m_gap--;
         if (m_gap == 0) m_phase = 0;
      end
      m_pend = (m_pend | r) & ~mask;
   endtask

   // Compare every cycle against the model, then advance it with this cycle's inputs.
   initial begin : model_checker
      logic [4:0] exp_v, act_v;
      forever begin
         @(negedge clk);
         if (!rst_n) model_reset();
         exp_v = {m_phase == 1, m_phase != 0, (m_phase == 1) && (m_el % NT == 0),
                  (m_phase == 1) && (m_el == SEQ_CYC - 1), m_pre};
         act_v = {tone_en, busy, note_strobe, done, preempted};
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL model_ctrl cyc %0d got %b expected %b (tone,busy,strobe,done,pre)", cyc, act_v, exp_v);
         end
         if (m_phase != 0) begin
            checks++;
            if (seq_sel !== 2'(m_sel)) begin
               errors++;
               $display("FAIL model_sel cyc %0d got %0d expected %0d", cyc, seq_sel, m_sel);
            end
         end
         if (m_phase == 1) begin
            checks++;
            if (note_idx !== 3'(m_el / NT)) begin
               errors++;
               $display("FAIL model_idx cyc %0d got %0d expected %0d", cyc, note_idx, m_el / NT);
            end
         end
         if (rst_n) model_step(req, flush);
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic pulse_req(input logic [3:0] r);
      @(posedge clk); #1 req = r;
      @(posedge clk); #1 req = 4'b0000;
   endtask

   task automatic wait_idx(input int idx, input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(tone_en && note_idx == 3'(idx)) && n < budget);
      chk("wait_idx_reached", int'(tone_en && note_idx == 3'(idx)), 1);
   endtask

   int o_tone, o_strobe, o_done, o_pre, o_first_tone, o_pre_cyc;
   bit o_pre_ok;
   int o_starts[$];
   int o_start_cyc[$];
   int o_done_cyc[$];

   // Watch outputs until busy has been low for quiet_need cycles.
   task automatic observe(input int quiet_need, input int budget);
      int quiet, i;
      quiet = 0; i = 0;
      o_tone = 0; o_strobe = 0; o_done = 0; o_pre = 0;
      o_first_tone = -1; o_pre_cyc = -1; o_pre_ok = 1'b0;
      o_starts.delete(); o_start_cyc.delete(); o_done_cyc.delete();
      while (quiet < quiet_need && i < budget) begin
         @(negedge clk);
         if (tone_en) begin
            o_tone++;
            if (o_first_tone < 0) o_first_tone = i;
         end
         if (note_strobe) begin
            o_strobe++;
            if (note_idx == 3'd0) begin
               o_starts.push_back(int'(seq_sel));
               o_start_cyc.push_back(i);
            end
         end
         if (done) begin
            o_done++;
            o_done_cyc.push_back(i);
         end
         if (preempted) begin
            o_pre++;
            o_pre_cyc = i;
            o_pre_ok = (seq_sel == 2'd3) && (note_idx == 3'd0) && note_strobe;
         end
         quiet = busy ? 0 : quiet + 1;
         i++;
      end
      chk("observe_settled", int'(quiet >= quiet_need), 1);
   endtask

   typedef struct packed {
      logic [3:0] req;
      logic [2:0] nseq;
      logic [7:0] ord;   // expected sequence IDs, first one in [1:0]
   } vec_t;

   // ---------------- stimulus ----------------
   initial begin : main
      vec_t       tbl [5];
      logic [7:0] ordv;
      logic [9:0] outs;
      int         n;

      tbl[0] = '{req: 4'b0001, nseq: 3'd1, ord: 8'h00};
      tbl[1] = '{req: 4'b0111, nseq: 3'd3, ord: 8'h12};
      tbl[2] = '{req: 4'b0010, nseq: 3'd1, ord: 8'h01};
      tbl[3] = '{req: 4'b1111, nseq: 3'd4, ord: 8'h4B};
      tbl[4] = '{req: 4'b1010, nseq: 3'd2, ord: 8'h07};

      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      outs = {seq_sel, note_idx, tone_en, note_strobe, busy, done, preempted};
      chk("reset_outputs", int'(outs), 0);
      @(posedge clk); #1 rst_n = 1'b1;

      // Table: single request pattern from idle -> order and shape of sequences.
      for (int t = 0; t < 5; t++) begin
         pulse_req(tbl[t].req);
         observe(4, 400);
         ordv = tbl[t].ord;
         n = int'(tbl[t].nseq);
         chk($sformatf("t%0d_num_seq", t), o_starts.size(), n);
         for (int j = 0; j < n && j < o_starts.size(); j++)
            chk($sformatf("t%0d_seq%0d_id", t, j), o_starts[j], int'(ordv[2*j +: 2]));
         chk($sformatf("t%0d_first_tone", t), o_first_tone, 1);
         chk($sformatf("t%0d_tone_cycles", t), o_tone, n * SEQ_CYC);
         chk($sformatf("t%0d_strobes", t), o_strobe, n * NN);
         chk($sformatf("t%0d_dones", t), o_done, n);
         chk($sformatf("t%0d_preempts", t), o_pre, 0);
         if (o_done_cyc.size() > 0 && o_start_cyc.size() > 0)
            chk($sformatf("t%0d_done_pos", t), o_done_cyc[0] - o_start_cyc[0], SEQ_CYC - 1);
         for (int j = 1; j < n && j < o_start_cyc.size() && j <= o_done_cyc.size(); j++)
            chk($sformatf("t%0d_spacing%0d", t, j), o_start_cyc[j] - o_done_cyc[j-1], GT + 2);
      end

      // End request pre-empts a start sequence at note 3.
      pulse_req(4'b0001);
      wait_idx(3, 100);
      pulse_req(4'b1000);
      observe(4, 200);
      chk("pre_count", o_pre, 1);
      chk("pre_cycle", o_pre_cyc, 1);
      chk("pre_outputs", int'(o_pre_ok), 1);
      chk("pre_dones", o_done, 1);
      chk("pre_tone_cycles", o_tone, 1 + SEQ_CYC);
      chk("pre_num_starts", o_starts.size(), 1);
      if (o_starts.size() > 0) chk("pre_start_id", o_starts[0], 3);

      // Two score requests during a score sequence -> exactly one replay.
      pulse_req(4'b0010);
      wait_idx(2, 100);
      pulse_req(4'b0010);
      wait_idx(5, 100);
      pulse_req(4'b0010);
      observe(4, 300);
      chk("replay_dones", o_done, 2);
      chk("replay_num_starts", o_starts.size(), 1);
      if (o_starts.size() > 0) chk("replay_id", o_starts[0], 1);

      // Flush mid-play with high score and score pending.
      pulse_req(4'b0001);
      wait_idx(2, 100);
      pulse_req(4'b0110);
      wait_idx(4, 100);
      @(posedge clk); #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      chk("flush_tone_en", int'(tone_en), 0);
      chk("flush_busy", int'(busy), 0);
      observe(10, 40);
      chk("flush_no_tone", o_tone, 0);
      chk("flush_no_grant", o_starts.size(), 0);

      // Asynchronous reset mid-note with a score request pending.
      pulse_req(4'b0100);
      wait_idx(1, 100);
      pulse_req(4'b0010);
      @(posedge clk); #3 rst_n = 1'b0;
      #1;
      outs = {seq_sel, note_idx, tone_en, note_strobe, busy, done, preempted};
      chk("async_reset_outputs", int'(outs), 0);
      @(posedge clk); #1 rst_n = 1'b1;
      pulse_req(4'b0001);
      observe(4, 200);
      chk("post_reset_first_tone", o_first_tone, 1);
      chk("post_reset_tone_cycles", o_tone, SEQ_CYC);
      chk("post_reset_num_starts", o_starts.size(), 1);
      if (o_starts.size() > 0) chk("post_reset_id", o_starts[0], 0);

      // Random traffic; the model checker compares every cycle.
      for (int k = 0; k < 3000; k++) begin
         @(posedge clk); #1;
         req   = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
         flush = ($urandom_range(0, 399) == 0);
      end
      @(posedge clk); #1 req = 4'b0000; flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      repeat (3) @(negedge clk);
      chk("final_idle", int'(busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
